// File: rtl/lfsr_vector_gen_if.sv
// ----------------------------------------------------------------------------
// lfsr_vector_gen_if
// Handshake and vector bus between a burst controller and lfsr_vector_gen.
//
// Signals:
//   start      controller -> generator  single-cycle burst request
//   seed_load  controller -> generator  load seed_in into the LFSR
//   seed_in    controller -> generator  seed value (VEC_WIDTH bits)
//   vec        generator  -> CUT        current vector (MSB = first CUT input)
//   vec_valid  generator  -> CUT        vec holds a burst vector
//   vec_idx    generator  -> CUT        index of the vector on vec
//   busy       generator  -> controller burst in progress
//   done       generator  -> controller sticky burst-complete flag
//
// Modports:
//   master  controller side (drives the requests, observes the vector bus)
//   slave   generator side
// ----------------------------------------------------------------------------
interface lfsr_vector_gen_if #(
    parameter int VEC_WIDTH = 41,
    parameter int IDX_W     = 16
);
    logic                 start;
    logic                 seed_load;
    logic [VEC_WIDTH-1:0] seed_in;
    logic [VEC_WIDTH-1:0] vec;
    logic                 vec_valid;
    logic [IDX_W-1:0]     vec_idx;
    logic                 busy;
    logic                 done;

    modport master (
        output start, seed_load, seed_in,
        input  vec, vec_valid, vec_idx, busy, done
    );

    modport slave (
        input  start, seed_load, seed_in,
        output vec, vec_valid, vec_idx, busy, done
    );
endinterface

// File: rtl/lfsr_vector_gen.sv
// ----------------------------------------------------------------------------
// lfsr_vector_gen
// On-chip stimulus source for an ISCAS85 circuit under test. Emits a burst of
// VEC_LENGTH pseudo-random vectors from a Fibonacci LFSR, each vector held for
// HOLD_CYCLES clocks, controlled by a start/busy/done handshake.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   lfsr_vector_gen_if.slave: start, seed_load, seed_in in;
//         vec, vec_valid, vec_idx, busy, done out
// ----------------------------------------------------------------------------
module lfsr_vector_gen #(
    parameter int                   VEC_WIDTH   = 41,
    parameter logic [VEC_WIDTH-1:0] POLY        = 41'h120_0000_0000,
    parameter logic [VEC_WIDTH-1:0] SEED        = 41'h1,
    parameter int                   VEC_LENGTH  = 10,
    parameter int                   HOLD_CYCLES = 1,
    parameter int                   IDX_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_vector_gen_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A one-cycle hold still needs a 1-bit counter so the logic stays uniform.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(VEC_LENGTH - 1);

    logic [1:0]           state_reg, state_next;
    logic [VEC_WIDTH-1:0] lfsr_reg,  lfsr_next;
    logic [VEC_WIDTH-1:0] vec_reg,   vec_next;
    logic [IDX_W-1:0]     idx_reg,   idx_next;
    logic [HOLD_W-1:0]    hold_reg,  hold_next;

    // Feedback taps: bit i participates when POLY[i] is set.
    logic [VEC_WIDTH-1:0] tap_bits;
    logic                 feedback;
    logic [VEC_WIDTH-1:0] lfsr_step;

    genvar gi;
    generate
        for (gi = 0; gi < VEC_WIDTH; gi++) begin : g_taps
            assign tap_bits[gi] = lfsr_reg[gi] & POLY[gi];
        end
    endgenerate

    assign feedback  = ^tap_bits;
    assign lfsr_step = {lfsr_reg[VEC_WIDTH-2:0], feedback};

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        vec_next   = vec_reg;
        idx_next   = idx_reg;
        hold_next  = hold_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // seed_load wins over start; an all-zero seed would lock the
                // LFSR, so it is replaced with SEED.
                if (bus.seed_load) begin
                    lfsr_next = (bus.seed_in == '0) ? SEED : bus.seed_in;
                end else if (bus.start) begin
                    vec_next   = lfsr_reg;
                    lfsr_next  = lfsr_step;
                    idx_next   = '0;
                    hold_next  = '0;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (hold_reg < HOLD_LAST) begin
                    hold_next = hold_reg + 1'b1;
                end else if (idx_reg == IDX_LAST) begin
                    // vec keeps the last vector and the LFSR keeps its advanced
                    // value so a later burst continues the sequence.
                    state_next = ST_DONE;
                end else begin
                    vec_next  = lfsr_reg;
                    lfsr_next = lfsr_step;
                    idx_next  = idx_reg + 1'b1;
                    hold_next = '0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            lfsr_reg  <= SEED;
            vec_reg   <= '0;
            idx_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            vec_reg   <= vec_next;
            idx_reg   <= idx_next;
            hold_reg  <= hold_next;
        end
    end

    // Status flags are decoded straight from the state, so busy and done can
    // never overlap and vec_valid always equals busy.
    assign bus.vec       = vec_reg;
    assign bus.vec_idx   = idx_reg;
    assign bus.busy      = (state_reg == ST_RUN);
    assign bus.vec_valid = (state_reg == ST_RUN);
    assign bus.done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_lfsr_vector_gen.sv
// ----------------------------------------------------------------------------
// tb_lfsr_vector_gen
// Self-checking bench for lfsr_vector_gen. Instance A uses the default
// parameters; instance B uses HOLD_CYCLES=3, VEC_LENGTH=2. Expected vectors
// come from a reference model of the LFSR rule (shift left, append parity of
// the tapped bits).
// ----------------------------------------------------------------------------
module tb_lfsr_vector_gen;

    localparam int             W     = 41;
    localparam int             IDX_W = 16;
    localparam int             LEN   = 10;
    localparam logic [W-1:0]   POLY  = 41'h120_0000_0000;
    localparam logic [W-1:0]   SEED  = 41'h1;
    localparam int             TIMEOUT_CYCLES = 20000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lfsr_vector_gen_if #(.VEC_WIDTH(W), .IDX_W(IDX_W)) bus_a ();
    lfsr_vector_gen_if #(.VEC_WIDTH(W), .IDX_W(IDX_W)) bus_b ();

    lfsr_vector_gen #(
        .VEC_WIDTH(W), .POLY(POLY), .SEED(SEED),
        .VEC_LENGTH(LEN), .HOLD_CYCLES(1), .IDX_W(IDX_W)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lfsr_vector_gen #(
        .VEC_WIDTH(W), .POLY(POLY), .SEED(SEED),
        .VEC_LENGTH(2), .HOLD_CYCLES(3), .IDX_W(IDX_W)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_a;
    logic         sim_done = 1'b0;

    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        if (!sim_done) begin
            errors++;
            $error("FAIL timeout: stimulus did not finish within %0d cycles", TIMEOUT_CYCLES);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next LFSR value: shift up one place, new LSB is the parity of the taps.
    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        int ones;
        ones = $countones(s & POLY);
        return (s << 1) | W'(ones % 2);
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic load_seed_a(input logic [W-1:0] s);
        @(negedge clk);
        bus_a.seed_load = 1'b1;
        bus_a.seed_in   = s;
        @(negedge clk);
        bus_a.seed_load = 1'b0;
        model_a = (s == '0) ? SEED : s;
        $display("seed load a: %h", s);
    endtask

    // One burst on instance A. first_exp pins the first vector; poke_at pulses
    // start+seed_load during RUN; rst_at resets the design at that index.
    task automatic run_burst_a(input string name, input logic [W-1:0] first_exp,
                               input int poke_at, input int rst_at);
        logic [W-1:0] last;
        last = '0;
        @(negedge clk);
        bus_a.start = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            bus_a.start     = 1'b0;
            bus_a.seed_load = 1'b0;
            $display("burst %s idx %0d vec %h", name, bus_a.vec_idx, bus_a.vec);
            if (k == 0) chk("first_vec", bus_a.vec, first_exp);
            checks++;
            if (bus_a.vec !== model_a) begin
                errors++;
                $error("FAIL vec: observed %0h expected %0h", bus_a.vec, model_a);
            end
            checks++;
            if (bus_a.vec_idx !== IDX_W'(k)) begin
                errors++;
                $error("FAIL vec_idx: observed %0d expected %0d", bus_a.vec_idx, k);
            end
            chk("vec_valid", bus_a.vec_valid, 1'b1);
            chk("busy", bus_a.busy, 1'b1);
            chk("done_low", bus_a.done, 1'b0);
            last    = model_a;
            model_a = model_step(model_a);
            if (k == poke_at) begin
                bus_a.start     = 1'b1;
                bus_a.seed_load = 1'b1;
                bus_a.seed_in   = rand_vec();
            end
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                $display("burst %s reset at idx %0d", name, k);
                chk("rst_vec", bus_a.vec, {W{1'b0}});
                chk("rst_idx", bus_a.vec_idx, {IDX_W{1'b0}});
                chk("rst_valid", bus_a.vec_valid, 1'b0);
                chk("rst_busy", bus_a.busy, 1'b0);
                chk("rst_done", bus_a.done, 1'b0);
                model_a = SEED;
                return;
            end
        end
        @(negedge clk);
        $display("burst %s end done=%b vec %h", name, bus_a.done, bus_a.vec);
        chk("end_valid", bus_a.vec_valid, 1'b0);
        chk("end_busy", bus_a.busy, 1'b0);
        chk("end_done", bus_a.done, 1'b1);
        chk("end_vec", bus_a.vec, last);
    endtask

    initial begin
        logic [W-1:0] s;
        int           valid_cycles;

        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.seed_load = 1'b0; bus_a.seed_in = '0;
        bus_b.start = 1'b0; bus_b.seed_load = 1'b0; bus_b.seed_in = '0;
        model_a = SEED;
        repeat (3) @(negedge clk);

        // Reset state.
        checks++;
        if (bus_a.vec !== {W{1'b0}} || bus_a.vec_valid !== 1'b0 ||
            bus_a.vec_idx !== {IDX_W{1'b0}} || bus_a.busy !== 1'b0 ||
            bus_a.done !== 1'b0) begin
            errors++;
            $error("FAIL reset_state: vec %0h valid %b idx %0d busy %b done %b",
                   bus_a.vec, bus_a.vec_valid, bus_a.vec_idx, bus_a.busy, bus_a.done);
        end
        $display("reset state: vec %h valid %b idx %0d busy %b done %b",
                 bus_a.vec, bus_a.vec_valid, bus_a.vec_idx, bus_a.busy, bus_a.done);
        chk("reset_vec", bus_a.vec, {W{1'b0}});
        chk("reset_valid", bus_a.vec_valid, 1'b0);
        chk("reset_idx", bus_a.vec_idx, {IDX_W{1'b0}});
        chk("reset_busy", bus_a.busy, 1'b0);
        chk("reset_done", bus_a.done, 1'b0);
        chk("reset_b_valid", bus_b.vec_valid, 1'b0);
        rst = 1'b0;

        // Default burst 0x1..0x200, then continuation from 0x400.
        run_burst_a("default", 41'h1, -1, -1);
        run_burst_a("continue", 41'h400, -1, -1);

        // All-ones seed, loaded from DONE: done must stay set.
        load_seed_a(41'h1FF_FFFF_FFFF);
        chk("load_keeps_done", bus_a.done, 1'b1);
        chk("load_no_busy", bus_a.busy, 1'b0);
        run_burst_a("ones", 41'h1FF_FFFF_FFFF, -1, -1);

        // Zero seed is substituted by SEED.
        load_seed_a('0);
        run_burst_a("zero_seed", 41'h1, -1, -1);

        // start together with seed_load in DONE: seed loads, no burst.
        s = rand_vec();
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.seed_load = 1'b1; bus_a.seed_in = s;
        @(negedge clk);
        bus_a.start = 1'b0; bus_a.seed_load = 1'b0;
        model_a = (s == '0) ? SEED : s;
        $display("start+seed_load a: %h", s);
        chk("both_busy", bus_a.busy, 1'b0);
        chk("both_valid", bus_a.vec_valid, 1'b0);
        chk("both_done", bus_a.done, 1'b1);
        @(negedge clk);
        chk("both_busy_later", bus_a.busy, 1'b0);
        run_burst_a("after_both", model_a, -1, -1);

        // start/seed_load poked mid-RUN must not disturb the burst.
        run_burst_a("poke", model_a, 3, -1);

        // Reset at vector 5, then a fresh burst restarts from SEED.
        run_burst_a("rst_mid", model_a, -1, 5);
        run_burst_a("after_rst", 41'h1, -1, -1);

        // Random seeds.
        for (int r = 0; r < 4; r++) begin
            s = ($urandom_range(0, 4) == 0) ? '0 : rand_vec();
            load_seed_a(s);
            run_burst_a("random", model_a, -1, -1);
        end

        // Instance B: each vector held 3 cycles, two vectors per burst.
        valid_cycles = 0;
        @(negedge clk);
        bus_b.start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            $display("burst hold cycle %0d valid %b idx %0d vec %h",
                     c, bus_b.vec_valid, bus_b.vec_idx, bus_b.vec);
            if (bus_b.vec_valid) valid_cycles++;
            if (c <= 6) begin
                checks++;
                if (bus_b.vec !== ((c <= 3) ? 41'h1 : 41'h2)) begin
                    errors++;
                    $error("FAIL hold_vec: cycle %0d observed %0h", c, bus_b.vec);
                end
                chk("hold_idx", bus_b.vec_idx, (c <= 3) ? 16'd0 : 16'd1);
                chk("hold_busy", bus_b.busy, 1'b1);
            end else begin
                chk("hold_done", bus_b.done, 1'b1);
                chk("hold_end_vec", bus_b.vec, 41'h2);
            end
        end
        chk("hold_valid_cycles", valid_cycles, 6);

        sim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
